tia_horizontal_timing_ctrl: RTL and testbench

//  Sequences the horizontal counter and decodes its line-timing windows for one scanline.
//  - Divides the color clock by 4 to produce the hphi1/hphi2 strobes for the horizontal LFSR.
//  - Keeps a binary shadow count 0..56 (57 counts x 4 clocks = 228 clocks/line).
//  - Decodes HSYNC, HBLANK, color burst and HMOVE late-HBLANK from that count.
//  - Services the RSYNC, WSYNC and HMOVE register strobes from the CPU bus decoder.

---
 rtl/tia_horizontal_timing_ctrl.sv | 103 ++++++++++
 tb/tb_tia_horizontal_timing_ctrl.sv | 128 ++++++++++++
 2 files changed

// File: rtl/tia_horizontal_timing_ctrl.sv
// Horizontal line sequencer for the TIA: divides the color clock by 4 into
// hphi1/hphi2 strobes, keeps a binary shadow of the horizontal count
// (57 counts x 4 clocks = 228 clocks per line), decodes the line-timing
// windows, and services the RSYNC / WSYNC / HMOVE register strobes.
//
// state         | meaning
// --------------+---------------------------------------------------------
// r_phase       | color-clock phase within a count, 0..3
// r_hcount      | horizontal count, 0..56
// r_hmove_latch | HMOVE pending/active for this line (extends HBLANK)
// r_wsync_hold  | CPU halted by WSYNC until the next line start
module tia_horizontal_timing_ctrl (
  input  logic       clk,
  input  logic       reset,
  input  logic       rsync_strobe,
  input  logic       wsync_strobe,
  input  logic       hmove_strobe,
  output logic       hphi1,
  output logic       hphi2,
  output logic [5:0] hcount,
  output logic       line_start,
  output logic       hsync,
  output logic       hblank,
  output logic       cburst,
  output logic       rdy,
  output logic       hmove_latch
);

  localparam logic [5:0] LAST_COUNT  = 6'd56;
  localparam logic [5:0] HBLANK_END  = 6'd17;
  localparam logic [5:0] LATE_HB_END = 6'd19;
  localparam logic [5:0] HSYNC_START = 6'd4;
  localparam logic [5:0] HSYNC_END   = 6'd8;
  localparam logic [5:0] CB_START    = 6'd8;
  localparam logic [5:0] CB_END      = 6'd12;

  logic [1:0] r_phase;
  logic [5:0] r_hcount;
  logic       r_hmove_latch;
  logic       r_wsync_hold;

  logic [1:0] w_phase_nxt;
  logic [5:0] w_hcount_nxt;
  logic       w_line_enter;
  logic       w_hmove_latch_nxt;
  logic       w_wsync_hold_nxt;

  // Next-state: RSYNC restarts the line, otherwise advance phase and count.
  // Counts at or beyond the last legal value all wrap to 0, which also
  // recovers from an illegal count.
  always_comb begin
    w_phase_nxt  = r_phase + 2'd1;
    w_hcount_nxt = r_hcount;
    w_line_enter = 1'b0;
    if (rsync_strobe) begin
      w_phase_nxt  = 2'd0;
      w_hcount_nxt = 6'd0;
      w_line_enter = 1'b1;
    end else if (r_phase == 2'd3) begin
      if (r_hcount >= LAST_COUNT) begin
        w_hcount_nxt = 6'd0;
        w_line_enter = 1'b1;
      end else begin
        w_hcount_nxt = r_hcount + 6'd1;
      end
    end
    // A strobe on the same edge as the line start wins over the clear.
    w_hmove_latch_nxt = hmove_strobe | (r_hmove_latch & ~w_line_enter);
    w_wsync_hold_nxt  = wsync_strobe | (r_wsync_hold  & ~w_line_enter);
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_phase       <= 2'd0;
      r_hcount      <= 6'd0;
      r_hmove_latch <= 1'b0;
      r_wsync_hold  <= 1'b0;
    end else begin
      r_phase       <= w_phase_nxt;
      r_hcount      <= w_hcount_nxt;
      r_hmove_latch <= w_hmove_latch_nxt;
      r_wsync_hold  <= w_wsync_hold_nxt;
    end
  end

  logic w_in_hblank;
  logic w_in_late_hb;
  assign w_in_hblank  = (r_hcount < HBLANK_END);
  assign w_in_late_hb = r_hmove_latch & (r_hcount < LATE_HB_END);

  // Outputs decode from state; reset forces the idle/blanked values.
  assign hphi1       = ~reset & (r_phase == 2'd0);
  assign hphi2       = ~reset & (r_phase == 2'd2);
  assign hcount      = r_hcount;
  assign line_start  = ~reset & (r_phase == 2'd0) & (r_hcount == 6'd0);
  assign hsync       = ~reset & (r_hcount >= HSYNC_START) & (r_hcount < HSYNC_END);
  assign cburst      = ~reset & (r_hcount >= CB_START) & (r_hcount < CB_END);
  assign hblank      = reset | w_in_hblank | w_in_late_hb;
  assign rdy         = reset | ~r_wsync_hold;
  assign hmove_latch = ~reset & r_hmove_latch;

endmodule

// File: tb/tb_tia_horizontal_timing_ctrl.sv
// Bench for tia_horizontal_timing_ctrl. The reference tracks the position
// within the 228-clock line directly and derives every output from it.
module tb_tia_horizontal_timing_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       rsync_strobe = 1'b0;
  logic       wsync_strobe = 1'b0;
  logic       hmove_strobe = 1'b0;
  logic       hphi1, hphi2, line_start, hsync, hblank, cburst, rdy, hmove_latch;
  logic [5:0] hcount;

  int n_total = 0;
  int n_bad   = 0;

  // reference model: clock position within the line, WSYNC hold, HMOVE latch
  int p = 0;
  bit m_hold = 1'b0;
  bit m_latch = 1'b0;

  tia_horizontal_timing_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .rsync_strobe (rsync_strobe),
    .wsync_strobe (wsync_strobe),
    .hmove_strobe (hmove_strobe),
    .hphi1        (hphi1),
    .hphi2        (hphi2),
    .hcount       (hcount),
    .line_start   (line_start),
    .hsync        (hsync),
    .hblank       (hblank),
    .cburst       (cburst),
    .rdy          (rdy),
    .hmove_latch  (hmove_latch)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_total++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got=%0d exp=%0d pos=%0d t=%0t", tag, got, exp, p, $time);
    end
  endtask

  // One clock: drive inputs, check outputs against the model, then advance the model.
  task automatic step(input bit r, input bit rs, input bit ws, input bit hm);
    bit newline;
    @(negedge clk);
    reset = r; rsync_strobe = rs; wsync_strobe = ws; hmove_strobe = hm;
    #1;
    chk("hphi1",      int'(hphi1),      int'(!r && (p % 4 == 0)));
    chk("hphi2",      int'(hphi2),      int'(!r && (p % 4 == 2)));
    chk("line_start", int'(line_start), int'(!r && p == 0));
    chk("hsync",      int'(hsync),      int'(!r && p >= 16 && p < 32));
    chk("cburst",     int'(cburst),     int'(!r && p >= 32 && p < 48));
    chk("hblank",     int'(hblank),     int'(r || p < 68 || (m_latch && p < 76)));
    chk("rdy",        int'(rdy),        int'(r || !m_hold));
    chk("hmove_latch", int'(hmove_latch), int'(!r && m_latch));
    if (!r) chk("hcount", int'(hcount), p / 4);
    @(posedge clk);
    if (r) begin
      p = 0; m_hold = 1'b0; m_latch = 1'b0;
    end else begin
      p = rs ? 0 : (p + 1) % 228;
      newline = (p == 0);
      m_hold  = ws ? 1'b1 : (newline ? 1'b0 : m_hold);
      m_latch = hm ? 1'b1 : (newline ? 1'b0 : m_latch);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic idle_to(input int target);
    for (int i = 0; i < 300 && p != target; i++) step(1'b0, 1'b0, 1'b0, 1'b0);
    if (p != target) begin
      n_total++;
      n_bad++;
      $display("FAIL reach_pos: got=%0d exp=%0d", p, target);
    end
  endtask

  initial begin
    bit r, rs, ws, hm;
    // reset, then free-run over two full lines
    repeat (3) step(1'b1, 1'b0, 1'b0, 1'b0);
    idle(500);
    // WSYNC mid-line, then WSYNC in the line_start cycle
    idle_to(100);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    idle_to(0);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    idle(300);
    // HMOVE early in a line: late HBLANK this line only
    idle_to(5);
    step(1'b0, 1'b0, 0, 1'b1);
    idle(460);
    // RSYNC with a pending WSYNC
    idle_to(90);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    idle_to(150);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    idle(300);
    // reset with WSYNC hold and HMOVE latch both set
    idle_to(10);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    idle_to(100);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    idle_to(120);
    repeat (3) step(1'b1, 1'b0, 1'b0, 1'b0);
    idle(300);
    // randomized strobes; HMOVE kept out of the late-HBLANK edge region
    for (int i = 0; i < 8000; i++) begin
      r  = ($urandom_range(0, 1999) == 0);
      rs = ($urandom_range(0, 299) == 0);
      ws = ($urandom_range(0, 99) == 0);
      hm = ($urandom_range(0, 99) == 0) && !(p >= 67 && p <= 75);
      step(r, rs, ws, hm);
    end
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
